// File: rtl/arbiter_types_pkg.sv
// Shared types and widths for the icache/dcache memory arbiter.
package arbiter_types;

  localparam int LINE_W = 256;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    SERVE_I,
    SERVE_D
  } arb_state_t;

  typedef enum logic {
    GRANT_I,
    GRANT_D
  } grant_t;

endpackage

// File: rtl/cache_arbiter.sv
// Two-client arbiter sharing one cacheline adaptor between icache and dcache.
// Alternates under contention; the grant is held until mem_resp.
module cache_arbiter
  import arbiter_types::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_resp
);

  arb_state_t state_q, state_d;
  grant_t     last_grant_q, last_grant_d;
  logic       d_wr_q, d_wr_d;
  logic       d_req;

  assign d_req   = d_read | d_write;
  assign i_rdata = mem_rdata;
  assign d_rdata = mem_rdata;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      d_wr_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      d_wr_q       <= d_wr_d;
    end
  end

  // d_wr_q captures the dcache op at grant so mem_read/mem_write
  // depend on registered state only.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    d_wr_d       = d_wr_q;
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_addr     = '0;
    mem_wdata    = '0;
    i_resp       = 1'b0;
    d_resp       = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (i_read && (!d_req || last_grant_q == GRANT_D)) begin
          state_d      = SERVE_I;
          last_grant_d = GRANT_I;
        end else if (d_req) begin
          state_d      = SERVE_D;
          last_grant_d = GRANT_D;
          d_wr_d       = d_write;
        end
      end
      SERVE_I: begin
        mem_read = 1'b1;
        mem_addr = i_addr;
        i_resp   = mem_resp;
        if (mem_resp) state_d = IDLE;
      end
      SERVE_D: begin
        mem_read  = ~d_wr_q;
        mem_write = d_wr_q;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        d_resp    = mem_resp;
        if (mem_resp) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule
